// File: rtl/fir_coeff_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coeff_loader_if
//  Description : Read bus between the coefficient loader and the coefficient
//                RAM. The loader drives a registered word address; the RAM
//                returns the addressed word a fixed number of clocks later.
//  Ports       : filter_coeff_addr  6-bit word address (loader -> RAM)
//                filter_coeff_data  32-bit read data   (RAM -> loader)
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_coeff_loader_if;

  logic [5:0]  filter_coeff_addr;
  logic [31:0] filter_coeff_data;

  // Loader side: issues addresses, consumes read data.
  modport master (
    output filter_coeff_addr,
    input  filter_coeff_data
  );

  // RAM side: accepts addresses, returns read data.
  modport slave (
    input  filter_coeff_addr,
    output filter_coeff_data
  );

endinterface
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fir_coeff_loader
//  Description : Coefficient set controller for the 5x5 FIR filter. Streams
//                NUM_TAPS tap words plus one normalisation-shift word from the
//                coefficient RAM into a shadow bank, then copies the shadow
//                bank to the active bank only on a rising edge of vs_i so the
//                MAC never sees a kernel change mid-frame.
//  Ports       : clk            system clock
//                rst            synchronous active-high reset
//                vs_i           vertical sync, rising edge is the commit point
//                reload_req     one-cycle pulse requesting a fresh load
//                ram            coefficient RAM read bus (master side)
//                coeff_o        active taps, tap k at [k*COEFF_W +: COEFF_W]
//                shift_o        active normalisation shift
//                coeff_valid_o  active bank holds a committed set
//                busy_o         high while reading / draining the RAM
//                commit_o       one-cycle pulse when the active bank updates
//  Revision    : 1.0  initial release
// ============================================================================
module fir_coeff_loader #(
  parameter int COEFF_W  = 18,
  parameter int NUM_TAPS = 25,
  parameter int RD_LAT   = 1,
  parameter int SHIFT_W  = 5
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          vs_i,
  input  wire logic                          reload_req,
  fir_coeff_loader_if.master                 ram,
  output logic [NUM_TAPS*COEFF_W-1:0]        coeff_o,
  output logic [SHIFT_W-1:0]                 shift_o,
  output logic                               coeff_valid_o,
  output logic                               busy_o,
  output logic                               commit_o
);

  localparam int                ADDR_W    = 6;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ARMED = 2'd3
  } state_t;

  state_t                       state;
  logic [ADDR_W-1:0]            addr;
  logic                         pending;
  logic                         vs_q;
  logic                         vs_rise;

  // Tag pipeline: each stage mirrors one clock of RAM read latency, so the
  // last stage names the word currently on filter_coeff_data.
  logic [RD_LAT-1:0]            tag_vld;
  logic [ADDR_W-1:0]            tag_addr [RD_LAT];
  logic                         cap_vld;
  logic [ADDR_W-1:0]            cap_addr;
  logic                         last_captured;

  logic [NUM_TAPS*COEFF_W-1:0]  shadow;
  logic [SHIFT_W-1:0]           shadow_shift;

  // Only the low COEFF_W / SHIFT_W data bits carry information.
  logic                         unused_data_bits;

  assign ram.filter_coeff_addr = addr;
  assign vs_rise               = vs_i & ~vs_q;
  assign cap_vld               = tag_vld[RD_LAT-1];
  assign cap_addr              = tag_addr[RD_LAT-1];
  assign last_captured         = cap_vld && (cap_addr == LAST_ADDR);
  assign unused_data_bits      = ^ram.filter_coeff_data;

  // --------------------------------------------------------------------------
  // Read tag pipeline. A tag enters on every READ cycle carrying the address
  // driven in that cycle; reset flushes it so a word requested before reset
  // can never land in the new shadow bank.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_addr[i] <= '0;
      end
    end else begin
      tag_vld[0]  <= (state == ST_READ);
      tag_addr[0] <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shadow bank capture. Taps are taken as raw two's-complement bit fields.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      shadow_shift <= '0;
    end else if (cap_vld) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (cap_addr == ADDR_W'(k)) begin
          shadow[k*COEFF_W +: COEFF_W] <= ram.filter_coeff_data[COEFF_W-1:0];
        end
      end
      if (cap_addr == LAST_ADDR) begin
        shadow_shift <= ram.filter_coeff_data[SHIFT_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs. pending comes up set out of reset so
  // the first set loads automatically.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      pending       <= 1'b1;
      vs_q          <= 1'b0;
      busy_o        <= 1'b0;
      commit_o      <= 1'b0;
      coeff_valid_o <= 1'b0;
      coeff_o       <= '0;
      shift_o       <= '0;
    end else begin
      vs_q     <= vs_i;
      commit_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pending) begin
            state   <= ST_READ;
            addr    <= '0;
            busy_o  <= 1'b1;
            pending <= 1'b0;
          end
        end

        ST_READ: begin
          if (addr == LAST_ADDR) begin
            state <= ST_DRAIN;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (last_captured) begin
            state  <= ST_ARMED;
            busy_o <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (vs_rise) begin
            coeff_o       <= shadow;
            shift_o       <= shadow_shift;
            coeff_valid_o <= 1'b1;
            commit_o      <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase

      // A request never restarts a load in progress; it is remembered and
      // serviced from IDLE. Placed last so a request arriving on the cycle a
      // load starts is not lost.
      if (reload_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
